// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register file dump reader: FSM state encoding
// and the order-sensitive checksum step.
package regfile_dump_reader_pkg;

    localparam int CHK_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    // Rotate left by one, then fold in the new word, so word order matters.
    function automatic logic [CHK_W-1:0] chkStep(input logic [CHK_W-1:0] acc,
                                                 input logic [CHK_W-1:0] data);
        return {acc[CHK_W-2:0], acc[CHK_W-1]} ^ data;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_checksum.sv
// Rotate-xor accumulator register; cleared at the start of every dump and
// advanced once per accepted word.
module dump_checksum
    import regfile_dump_reader_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Enable,
    input  logic [CHK_W-1:0] Data,
    output logic [CHK_W-1:0] Sum
);

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            Sum <= '0;
        end else if (Enable) begin
            Sum <= chkStep(Sum, Data);
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register address range through an async read port and streams each
// captured word over valid/ready, keeping a running checksum.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int WIDTH  = CHK_W,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] FirstReg,
    input  logic [ADDR_W-1:0] LastReg,
    output logic [ADDR_W-1:0] ReadRegister,
    input  logic [WIDTH-1:0]  ReadData,
    output logic [WIDTH-1:0]  DumpData,
    output logic [ADDR_W-1:0] DumpAddr,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic              Busy,
    output logic              Done,
    output logic [WIDTH-1:0]  Checksum
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] lastReg;
    logic              chkClear;
    logic              handshake;

    assign chkClear  = (state == IDLE) && Start;
    assign handshake = (state == SEND) && DumpValid && DumpReady;

    // ReadRegister doubles as the walk address: it is the value the file sees
    // throughout READ and SEND, and it returns to 0 once the walk ends.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            lastReg      <= '0;
            ReadRegister <= '0;
            DumpData     <= '0;
            DumpAddr     <= '0;
            DumpValid    <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        lastReg      <= LastReg;
                        ReadRegister <= FirstReg;
                        Busy         <= 1'b1;
                        state        <= READ;
                    end
                end
                READ: begin
                    DumpData  <= ReadData;
                    DumpAddr  <= ReadRegister;
                    DumpValid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        DumpValid <= 1'b0;
                        if (ReadRegister == lastReg) begin
                            ReadRegister <= '0;
                            Done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            ReadRegister <= ReadRegister + ADDR_ONE;
                            state        <= READ;
                        end
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dump_checksum u_checksum (
        .Clk    (Clk),
        .Reset  (Reset),
        .Clear  (chkClear),
        .Enable (handshake),
        .Data   (DumpData),
        .Sum    (Checksum)
    );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural register file, handshake monitor
// and a queue-based model of the expected word stream and checksum.
module tb_regfile_dump_reader;

    localparam int W  = 32;
    localparam int AW = 5;

    typedef logic [W-1:0] wq_t[$];
    typedef struct {
        logic [AW-1:0] first;
        logic [AW-1:0] last;
        int            readyMode;
        int            expN;
    } vec_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [AW-1:0] FirstReg, LastReg, ReadRegister, DumpAddr;
    logic [W-1:0]  ReadData, DumpData, Checksum;
    logic          DumpValid, DumpReady, Busy, Done;

    logic [W-1:0]  rf [32];
    assign ReadData = rf[ReadRegister];

    always #5 Clk = ~Clk;

    regfile_dump_reader #(.WIDTH(W), .ADDR_W(AW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .FirstReg     (FirstReg),
        .LastReg      (LastReg),
        .ReadRegister (ReadRegister),
        .ReadData     (ReadData),
        .DumpData     (DumpData),
        .DumpAddr     (DumpAddr),
        .DumpValid    (DumpValid),
        .DumpReady    (DumpReady),
        .Busy         (Busy),
        .Done         (Done),
        .Checksum     (Checksum)
    );

    int nTests = 0;
    int nFail  = 0;

    // Monitor: records handshakes, Done pulses and protocol violations.
    logic [AW-1:0] hsAddr[$];
    logic [W-1:0]  hsData[$];
    int            doneCnt  = 0;
    int            stallErr = 0;
    int            rrErr    = 0;
    logic          prevStall = 1'b0;
    logic [AW-1:0] prevA = '0;
    logic [W-1:0]  prevD = '0;

    always @(negedge Clk) begin
        if (prevStall && (DumpValid !== 1'b1 || DumpAddr !== prevA || DumpData !== prevD))
            stallErr++;
        if (DumpValid === 1'b1 && Reset === 1'b0 && ReadRegister !== DumpAddr)
            rrErr++;
        if (DumpValid === 1'b1 && DumpReady === 1'b1 && Reset === 1'b0) begin
            hsAddr.push_back(DumpAddr);
            hsData.push_back(DumpData);
        end
        if (Done === 1'b1 && Reset === 1'b0)
            doneCnt++;
        prevStall = (DumpValid === 1'b1) && (DumpReady === 1'b0) && (Reset === 1'b0);
        prevA     = DumpAddr;
        prevD     = DumpData;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic wq_t buildExp(input logic [AW-1:0] f, input int n);
        wq_t q;
        for (int i = 0; i < n; i++) q.push_back(rf[(int'(f) + i) % 32]);
        return q;
    endfunction

    function automatic logic [W-1:0] csumModel(input wq_t d);
        logic [W-1:0] c = '0;
        foreach (d[i]) c = ((c << 1) | (c >> (W - 1))) ^ d[i];
        return c;
    endfunction

    task automatic startDump(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(negedge Clk);
        FirstReg = f;
        LastReg  = l;
        Start    = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // Drives DumpReady until Done shows up; cycles counts edges since the call.
    task automatic runReady(input int mode, output int cycles);
        cycles = 0;
        while (Done !== 1'b1 && cycles < 400) begin
            DumpReady = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
            @(posedge Clk);
            #1;
            cycles++;
        end
        if (Done !== 1'b1) check("done_timeout", 64'(Done), 64'd1);
    endtask

    task automatic compareRun(input string name, input logic [AW-1:0] f, input int expN,
                              input int hs0, input int done0, input wq_t expD);
        int got = hsAddr.size() - hs0;
        check({name, "_count"}, 64'(got), 64'(expN));
        for (int i = 0; i < expN && i < got; i++) begin
            check({name, "_addr"}, 64'(hsAddr[hs0 + i]), 64'((int'(f) + i) % 32));
            check({name, "_data"}, 64'(hsData[hs0 + i]), 64'(expD[i]));
        end
        check({name, "_checksum"}, 64'(Checksum), 64'(csumModel(expD)));
        check({name, "_done_pulses"}, 64'(doneCnt - done0), 64'd1);
        check({name, "_stall_stable"}, 64'(stallErr), 64'd0);
        check({name, "_rdreg_stable"}, 64'(rrErr), 64'd0);
    endtask

    task automatic doRun(input string name, input logic [AW-1:0] f, input logic [AW-1:0] l,
                         input int mode, input int expN);
        wq_t expD = buildExp(f, expN);
        int  hs0 = hsAddr.size();
        int  done0 = doneCnt;
        int  cyc;
        startDump(f, l);
        check({name, "_busy_start"}, 64'(Busy), 64'd1);
        runReady(mode, cyc);
        if (mode == 0) check({name, "_cycles"}, 64'(cyc), 64'(2 * expN));
        @(posedge Clk);
        #1;
        check({name, "_busy_end"}, 64'(Busy), 64'd0);
        check({name, "_done_end"}, 64'(Done), 64'd0);
        compareRun(name, f, expN, hs0, done0, expD);
    endtask

    vec_t tbl[5];

    initial begin
        int hs0, done0, cyc, budget;
        logic [AW-1:0] rf_, rl_;

        tbl[0] = '{first: 5'd0,  last: 5'd31, readyMode: 0, expN: 32};
        tbl[1] = '{first: 5'd30, last: 5'd1,  readyMode: 1, expN: 4};
        tbl[2] = '{first: 5'd9,  last: 5'd9,  readyMode: 1, expN: 1};
        tbl[3] = '{first: 5'd31, last: 5'd0,  readyMode: 0, expN: 2};
        tbl[4] = '{first: 5'd3,  last: 5'd10, readyMode: 1, expN: 8};

        for (int i = 0; i < 32; i++) rf[i] = W'(i) * 32'h1111_1111;
        Reset = 1'b1; Start = 1'b1; FirstReg = 5'd3; LastReg = 5'd7; DumpReady = 1'b0;

        // Reset with Start held: everything stays at zero.
        repeat (3) @(posedge Clk);
        #1;
        check("rst_rdreg", 64'(ReadRegister), 64'd0);
        check("rst_data", 64'(DumpData), 64'd0);
        check("rst_addr", 64'(DumpAddr), 64'd0);
        check("rst_valid", 64'(DumpValid), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_checksum", 64'(Checksum), 64'd0);
        Start = 1'b0; Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("post_rst_busy", 64'(Busy), 64'd0);

        for (int i = 0; i < 5; i++)
            doRun($sformatf("tbl%0d", i), tbl[i].first, tbl[i].last, tbl[i].readyMode, tbl[i].expN);

        // Start held high through Done: one word, one Done, no restart in DONE.
        hs0 = hsAddr.size(); done0 = doneCnt;
        @(negedge Clk);
        FirstReg = 5'd5; LastReg = 5'd5; Start = 1'b1;
        @(posedge Clk);
        #1;
        runReady(0, cyc);
        @(posedge Clk);
        #1;
        check("hold_busy_after_done", 64'(Busy), 64'd0);
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("hold_busy_idle", 64'(Busy), 64'd0);
        check("hold_words", 64'(hsAddr.size() - hs0), 64'd1);
        check("hold_addr", 64'(hsAddr[hs0]), 64'd5);
        check("hold_data", 64'(hsData[hs0]), 64'h5555_5555);
        check("hold_done_pulses", 64'(doneCnt - done0), 64'd1);

        // Reset while a word is waiting in SEND after three handshakes.
        hs0 = hsAddr.size(); done0 = doneCnt;
        startDump(5'd0, 5'd31);
        DumpReady = 1'b1;
        budget = 0;
        while (hsAddr.size() < hs0 + 3 && budget < 50) begin
            @(posedge Clk);
            #1;
            budget++;
        end
        check("abort_three_words", 64'(hsAddr.size() - hs0), 64'd3);
        DumpReady = 1'b0;
        @(posedge Clk);
        #1;
        check("abort_in_send", 64'(DumpValid), 64'd1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("abort_valid", 64'(DumpValid), 64'd0);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_rdreg", 64'(ReadRegister), 64'd0);
        check("abort_data", 64'(DumpData), 64'd0);
        check("abort_checksum", 64'(Checksum), 64'd0);
        repeat (3) @(posedge Clk);
        #1;
        check("abort_no_done", 64'(doneCnt - done0), 64'd0);
        check("abort_still_idle", 64'(Busy), 64'd0);
        doRun("after_abort", 5'd2, 5'd4, 1, 3);

        // Write to r7 on the same edge the reader captures it.
        rf[7] = 32'h1234_5678;
        hs0 = hsAddr.size();
        startDump(5'd7, 5'd7);
        @(posedge Clk);
        rf[7] <= 32'hDEAD_BEEF;
        #1;
        runReady(0, cyc);
        @(posedge Clk);
        #1;
        check("wr_race_count", 64'(hsAddr.size() - hs0), 64'd1);
        check("wr_race_old", 64'(hsData[hs0]), 64'h1234_5678);
        hs0 = hsAddr.size();
        doRun("wr_race_new", 5'd7, 5'd7, 0, 1);
        check("wr_race_new_val", 64'(hsData[hs0]), 64'hDEAD_BEEF);

        // Random contents, ranges and consumer stalls.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            rf_ = AW'($urandom_range(0, 31));
            rl_ = AW'($urandom_range(0, 31));
            doRun($sformatf("rand%0d", t), rf_, rl_, int'($urandom_range(0, 1)),
                  ((int'(rl_) - int'(rf_) + 32) % 32) + 1);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
